pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage core. Drives per-stage enable/bubble controls
//  for PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
//  Arbitrates three hazard sources: data-memory wait (handshake), taken branch/jump, load-use.
//  Owns the dmem request handshake, a wait-timeout watchdog and a sticky error state.
// PARAMETERS
//  MEM_TIMEOUT  64  max consecutive MEM_WAIT cycles before ERR (>=1)
// PORTS
//  clk             in   1   clock
//  reset           in   1   synchronous, active-high
//  id_rs1/id_rs2   in   5   source regs of instruction in ID
//  id_use_rs1/rs2  in   1   ID instruction actually reads rs1/rs2
//  ex_mem_read     in   1   instruction in EX is a load
//  ex_rd           in   5   destination reg of instruction in EX
//  ex_branch_taken in   1   EX resolved taken branch/jump (redirect this cycle)
//  mem_access      in   1   instruction in MEM is load/store
//  dmem_ready      in   1   data memory completes access this cycle
//  dmem_req        out  1   data memory request
//  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out 1  register enables
//  if_id_bubble, id_ex_bubble, mem_wb_bubble        out 1  zero ctrl signals loaded into stage
//  err             out  1   sticky memory-timeout error
//  stall_cycles    out  32  perf counter (PIPE_PERF_CNT_EN)
//  flush_count     out  32  perf counter (PIPE_PERF_CNT_EN)
// BEHAVIOUR
//  Reset: state=RUN, wait_cnt=0, err=0, counters=0; all enables 1, all bubbles 0, dmem_req 0.
//  Outputs are combinational from state+inputs; zero added latency.
//  dmem_req = mem_access & (state!=ERR). Access completes on dmem_req & dmem_ready.
//  Priority per cycle: ERR > mem stall > branch flush > load-use.
//  RUN:
//   - mem_access & !dmem_ready: pc/if_id/id_ex/ex_mem en=0; mem_wb_en=1, mem_wb_bubble=1;
//     -> MEM_WAIT, wait_cnt=1. Pending branch/load-use not acted on this cycle.
//   - else ex_branch_taken: all en=1; if_id_bubble=1, id_ex_bubble=1.
//   - else load-use (ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) |
//     (id_use_rs2 & id_rs2==ex_rd))): pc_en=0, if_id_en=0, id_ex_bubble=1; rest en=1.
//   - else: all en=1, no bubbles.
//  MEM_WAIT: same freeze as above each cycle while !dmem_ready; wait_cnt++ per cycle.
//   - dmem_ready: -> RUN; this cycle evaluated exactly as RUN with memory satisfied
//     (branch/load-use rules apply); wait_cnt=0.
//   - wait_cnt==MEM_TIMEOUT & !dmem_ready: -> ERR.
//   - dmem_ready in the same cycle as timeout: ready wins, -> RUN.
//  ERR: all en=0, bubbles 0, dmem_req=0, err=1; exits only on reset.
//  Reset mid-wait: immediate return to RUN, dmem_req drops same cycle as reset asserts.
//  ex_rd==0 never triggers load-use. wait_cnt width $clog2(MEM_TIMEOUT+1), never wraps.
// CONFIGURATION
//  `PIPE_PERF_CNT_EN defined: stall_cycles +1 each cycle pc_en==0 (not in ERR);
//   flush_count +1 each cycle if_id_bubble==1; both wrap at 2^32.
//  Undefined: both ports present, tied to 0, no counter flops.
// STRUCTURE
//  Package pipeline_ctrl_pkg: typedef enum logic[1:0] {RUN, MEM_WAIT, ERR} pipe_state_t;
//   typedef enum {HZ_NONE, HZ_MEM, HZ_BRANCH, HZ_LOAD_USE} hazard_t; REG_ZERO=5'd0.
//  Sub-module load_use_detect: combinational rs/rd compare, outputs 1-bit hazard.
//  Top holds FSM, watchdog counter, priority mux, perf counters.
// TESTING
//  1 Reset held 2 cyc -> all en=1, bubbles=0, err=0, dmem_req=0, counters=0.
//  2 ex_mem_read=1,ex_rd=5,id_rs1=5,id_use_rs1=1 -> pc_en=0,if_id_en=0,id_ex_bubble=1 for 1 cyc.
//  3 Same with ex_rd=0 -> no stall; with ex_branch_taken=1 -> bubbles IF/ID+ID/EX, pc_en=1.
//  4 mem_access=1, dmem_ready low 3 cyc then high -> 3 cyc frozen+mem_wb_bubble, RUN on 4th,
//    stall_cycles=3 (PIPE_PERF_CNT_EN).
//  5 MEM_TIMEOUT=4, dmem_ready never -> ERR after 4 wait cyc, err=1, all en=0 until reset.
//  6 Reset asserted during MEM_WAIT -> RUN next edge, dmem_req=0, wait_cnt=0, err=0.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types for the pipeline stall/flush sequencer.
//   pipe_state_t : sequencer FSM states
//   hazard_t     : winning hazard for the current cycle after prioritisation
//   REG_ZERO     : x0 register index; never a real producer
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} pipe_state_t;
  typedef enum {HZ_NONE, HZ_MEM, HZ_BRANCH, HZ_LOAD_USE} hazard_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// pipeline_stall_ctrl_if: hazard inputs, dmem handshake and per-stage controls.
//   slave  : the sequencer (consumes hazard info, drives enables/bubbles/dmem_req)
//   master : the core datapath / bench (drives hazard info, consumes controls)
interface pipeline_stall_ctrl_if;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
  logic        mem_access, dmem_ready, dmem_req;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_bubble, id_ex_bubble, mem_wb_bubble;
  logic        err;
  logic [31:0] stall_cycles, flush_count;

  modport slave (
    input  id_rs1, id_rs2, ex_rd, id_use_rs1, id_use_rs2, ex_mem_read,
           ex_branch_taken, mem_access, dmem_ready,
    output dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_bubble, id_ex_bubble, mem_wb_bubble, err,
           stall_cycles, flush_count
  );

  modport master (
    output id_rs1, id_rs2, ex_rd, id_use_rs1, id_use_rs2, ex_mem_read,
           ex_branch_taken, mem_access, dmem_ready,
    input  dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_bubble, id_ex_bubble, mem_wb_bubble, err,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_stall_ctrl_load_use_detect.sv
// load_use_detect: flags a load in EX whose destination feeds the ID instruction.
//   i_id_rs1/i_id_rs2, i_id_use_rs1/i_id_use_rs2 : ID source regs and their use
//   i_ex_mem_read, i_ex_rd                       : EX load flag and destination
//   o_hazard                                     : 1 = ID must wait one cycle
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_use_rs1,
  input  logic       i_id_use_rs2,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rd,
  output logic       o_hazard
);
  // x0 writes are discarded, so a load to x0 never creates a dependency.
  assign o_hazard = i_ex_mem_read & (i_ex_rd != REG_ZERO) &
                    ((i_id_use_rs1 & (i_id_rs1 == i_ex_rd)) |
                     (i_id_use_rs2 & (i_id_rs2 == i_ex_rd)));
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: stall/flush sequencer for the 5-stage core.
//   clk, reset : clock, synchronous active-high reset
//   bus        : pipeline_stall_ctrl_if.slave (hazard inputs, dmem handshake,
//                stage enables/bubbles, sticky err, perf counters)
// Parameter MEM_TIMEOUT: max consecutive MEM_WAIT cycles before ERR (>=1).
// Optional macro PIPE_PERF_CNT_EN: enables stall_cycles/flush_count counters;
// when undefined both ports read 0 and no counter flops exist.
module pipeline_stall_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_stall_ctrl_if.slave  bus
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  pipe_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic    w_load_use, w_mem_stall;
  hazard_t w_hazard;
  logic    w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en;
  logic    w_if_id_bub, w_id_ex_bub, w_mem_wb_bub, w_err, w_dmem_req;

  load_use_detect u_lud (
    .i_id_rs1      (bus.id_rs1),
    .i_id_rs2      (bus.id_rs2),
    .i_id_use_rs1  (bus.id_use_rs1),
    .i_id_use_rs2  (bus.id_use_rs2),
    .i_ex_mem_read (bus.ex_mem_read),
    .i_ex_rd       (bus.ex_rd),
    .o_hazard      (w_load_use)
  );

  // Once waiting, only dmem_ready releases the freeze.
  always_comb begin
    w_mem_stall = 1'b0;
    case (r_state)
      RUN:      w_mem_stall = bus.mem_access & ~bus.dmem_ready;
      MEM_WAIT: w_mem_stall = ~bus.dmem_ready;
      default:  w_mem_stall = 1'b0;
    endcase
  end

  always_comb begin
    w_hazard = HZ_NONE;
    if (w_mem_stall)              w_hazard = HZ_MEM;
    else if (bus.ex_branch_taken) w_hazard = HZ_BRANCH;
    else if (w_load_use)          w_hazard = HZ_LOAD_USE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // A ready arriving on the timeout cycle still completes the access.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      RUN: if (w_mem_stall) begin
        w_state_nxt    = MEM_WAIT;
        w_wait_cnt_nxt = CW'(1);
      end
      MEM_WAIT: begin
        if (bus.dmem_ready) begin
          w_state_nxt    = RUN;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt == CW'(MEM_TIMEOUT)) begin
          w_state_nxt    = ERR;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CW'(1);
        end
      end
      default: w_state_nxt = ERR;
    endcase
  end

  // Outputs are forced to their reset values while reset is high so a
  // pending dmem request is withdrawn in the same cycle reset asserts.
  always_comb begin
    w_pc_en      = 1'b1; w_if_id_en  = 1'b1; w_id_ex_en   = 1'b1;
    w_ex_mem_en  = 1'b1; w_mem_wb_en = 1'b1;
    w_if_id_bub  = 1'b0; w_id_ex_bub = 1'b0; w_mem_wb_bub = 1'b0;
    w_err        = 1'b0;
    w_dmem_req   = bus.mem_access & (r_state != ERR) & ~reset;
    if (reset) begin
      w_dmem_req = 1'b0;
    end else if (r_state == ERR) begin
      w_pc_en = 1'b0; w_if_id_en = 1'b0; w_id_ex_en = 1'b0;
      w_ex_mem_en = 1'b0; w_mem_wb_en = 1'b0;
      w_err = 1'b1;
    end else begin
      case (w_hazard)
        HZ_MEM: begin
          // MEM/WB keeps advancing with a bubble so WB drains.
          w_pc_en = 1'b0; w_if_id_en = 1'b0; w_id_ex_en = 1'b0;
          w_ex_mem_en = 1'b0; w_mem_wb_bub = 1'b1;
        end
        HZ_BRANCH: begin
          w_if_id_bub = 1'b1; w_id_ex_bub = 1'b1;
        end
        HZ_LOAD_USE: begin
          w_pc_en = 1'b0; w_if_id_en = 1'b0; w_id_ex_bub = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.dmem_req      = w_dmem_req;
  assign bus.pc_en         = w_pc_en;
  assign bus.if_id_en      = w_if_id_en;
  assign bus.id_ex_en      = w_id_ex_en;
  assign bus.ex_mem_en     = w_ex_mem_en;
  assign bus.mem_wb_en     = w_mem_wb_en;
  assign bus.if_id_bubble  = w_if_id_bub;
  assign bus.id_ex_bubble  = w_id_ex_bub;
  assign bus.mem_wb_bubble = w_mem_wb_bub;
  assign bus.err           = w_err;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_stall_cycles, r_flush_count;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (~w_pc_en & (r_state != ERR)) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_if_id_bub)                 r_flush_count  <= r_flush_count + 32'd1;
    end
  end
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_count  = r_flush_count;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_count  = '0;
`endif
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;
  // ctrl vector: {dmem_req, pc, if_id, id_ex, ex_mem, mem_wb en, if_id_b, id_ex_b, mem_wb_b, err}
  localparam logic [9:0] NORM = 10'b0111110000;
  localparam logic [9:0] LU   = 10'b0001110100;
  localparam logic [9:0] LUM  = 10'b1001110100;
  localparam logic [9:0] BR   = 10'b0111111100;
  localparam logic [9:0] BRM  = 10'b1111111100;
  localparam logic [9:0] MST  = 10'b1000010010;
  localparam logic [9:0] MDN  = 10'b1111110000;
  localparam logic [9:0] ERRV = 10'b0000000001;

  typedef struct {
    logic [9:0]  ctrl;
    logic        chk_cnt;
    logic [31:0] st;
    logic [31:0] fl;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipeline_stall_ctrl_if bus ();
  pipeline_stall_ctrl #(.MEM_TIMEOUT(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   vec_no  = 0;
  int   tally_s = 0;
  int   tally_f = 0;
  logic cnt_known = 1'b0;

  task automatic drv(input logic rst, input logic ma, input logic rdy, input logic bt,
                     input logic mr, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2,
                     input logic [9:0] exp_ctrl);
    exp_t e;
    @(posedge clk); #1;
    reset = rst;
    bus.mem_access = ma; bus.dmem_ready = rdy; bus.ex_branch_taken = bt;
    bus.ex_mem_read = mr; bus.ex_rd = rd;
    bus.id_rs1 = rs1; bus.id_use_rs1 = u1; bus.id_rs2 = rs2; bus.id_use_rs2 = u2;
    e.ctrl = exp_ctrl;
    e.chk_cnt = cnt_known;
`ifdef PIPE_PERF_CNT_EN
    e.st = 32'(tally_s);
    e.fl = 32'(tally_f);
`else
    e.st = '0;
    e.fl = '0;
`endif
    q.push_back(e);
    if (rst) begin
      tally_s = 0; tally_f = 0; cnt_known = 1'b1;
    end else begin
      if (!exp_ctrl[8] && !exp_ctrl[0]) tally_s++;
      if (exp_ctrl[3]) tally_f++;
    end
  endtask

  task automatic idle(input logic [9:0] exp_ctrl);
    drv(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, exp_ctrl);
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    logic [9:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        vec_no++;
        act = {bus.dmem_req, bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
               bus.mem_wb_en, bus.if_id_bubble, bus.id_ex_bubble, bus.mem_wb_bubble, bus.err};
        n_tests++;
        if (act !== e.ctrl) begin
          n_fail++;
          $display("FAIL ctrl vec%0d: got %b want %b", vec_no, act, e.ctrl);
        end
        if (e.chk_cnt) begin
          n_tests++;
          if (bus.stall_cycles !== e.st || bus.flush_count !== e.fl) begin
            n_fail++;
            $display("FAIL counters vec%0d: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                     vec_no, bus.stall_cycles, bus.flush_count, e.st, e.fl);
          end
        end
      end
    end
  end

  initial begin
    int waited;
    bus.mem_access = 0; bus.dmem_ready = 0; bus.ex_branch_taken = 0;
    bus.ex_mem_read = 0; bus.ex_rd = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
    bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
    // reset held two cycles
    drv(1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, NORM);
    drv(1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, NORM);
    idle(NORM);
    // load-use via rs1, rs2; unused rs2; ex_rd==0; not a load
    drv(0, 0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, LU);
    idle(NORM);
    drv(0, 0, 0, 0, 1, 5'd7, 5'd3, 1, 5'd7, 1, LU);
    drv(0, 0, 0, 0, 1, 5'd7, 5'd3, 1, 5'd7, 0, NORM);
    drv(0, 0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1, NORM);
    drv(0, 0, 0, 0, 0, 5'd5, 5'd5, 1, 5'd0, 0, NORM);
    // branch beats load-use
    drv(0, 0, 0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0, BR);
    // mem wait 3 cycles then ready
    drv(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, MST);
    drv(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, MST);
    drv(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, MST);
    drv(0, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, MDN);
    idle(NORM);
    // mem stall beats branch; branch / load-use act on completion cycle
    drv(0, 1, 0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0, MST);
    drv(0, 1, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, BRM);
    drv(0, 1, 1, 0, 1, 5'd9, 5'd0, 0, 5'd9, 1, LUM);
    // reset during MEM_WAIT clears wait count
    drv(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, MST);
    drv(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, MST);
    drv(1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, NORM);
    // ready on the timeout cycle wins
    for (int i = 0; i < 4; i++) drv(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, MST);
    drv(0, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, MDN);
    idle(NORM);
    // timeout -> sticky ERR
    for (int i = 0; i < 5; i++) drv(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, MST);
    drv(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, ERRV);
    drv(0, 1, 1, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0, ERRV);
    idle(ERRV);
    drv(1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, NORM);
    idle(NORM);
    idle(NORM);
    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected vectors left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
